// File: rtl/event_write_arbiter_pkg.sv
// Shared types and constants for the event write arbiter.
// State encoding, header tag, default burst length, index-width helper.
package event_write_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] HEADER_TAG = 8'hEA;
    localparam int DEFAULT_WORDS_PER_EVENT = 16;

    // Index width that stays legal for a single-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/event_write_arbiter_rr_arbiter.sv
// Combinational round-robin selector: first set request at or above ptr.
// Ports: req (request vector), ptr (priority pointer), grant (one-hot), grant_idx.
module rr_arbiter
    import event_write_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IW = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    grant_idx
);

    logic          found;
    logic [IW:0]   j;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = '0;
        for (int i = 0; i < N_REQ; i++) begin
            // Walk upward from the pointer, wrapping modulo N_REQ.
            j = {1'b0, ptr} + (IW+1)'(i);
            if (j >= (IW+1)'(N_REQ))
                j = j - (IW+1)'(N_REQ);
            if (!found && req[j[IW-1:0]]) begin
                found                 = 1'b1;
                grant[j[IW-1:0]]      = 1'b1;
                grant_idx             = j[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/event_write_arbiter.sv
// Round-robin arbiter moving fixed-length event bursts into one shared FIFO.
// Ports: clk, aresetn, req_i, data_i, full_i -> wr_en_o, din_o, ack_o, done_o,
//        grant_id_o, busy_o. Optional macro EVENT_HEADER_EN adds a header word.
module event_write_arbiter
    import event_write_arbiter_pkg::*;
#(
    parameter int N_REQ           = 4,
    parameter int WORDS_PER_EVENT = DEFAULT_WORDS_PER_EVENT,
    localparam int IW = idx_width(N_REQ),
    localparam int CW = $clog2(WORDS_PER_EVENT + 1)
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic [N_REQ-1:0]      req_i,
    input  logic [N_REQ*64-1:0]   data_i,
    input  logic                  full_i,
    output logic                  wr_en_o,
    output logic [63:0]           din_o,
    output logic [N_REQ-1:0]      ack_o,
    output logic [N_REQ-1:0]      done_o,
    output logic [IW-1:0]         grant_id_o,
    output logic                  busy_o
);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [IW-1:0]     ptr;
    logic [N_REQ-1:0]  gnt_oh;
    logic [N_REQ-1:0]  rr_grant;
    logic [IW-1:0]     rr_idx;
    logic              hdr_phase;

`ifdef EVENT_HEADER_EN
    logic              hdr_pend;
    logic [31:0]       ev_cnt;
`endif

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req       (req_i),
        .ptr       (ptr),
        .grant     (rr_grant),
        .grant_idx (rr_idx)
    );

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            cnt        <= '0;
            ptr        <= '0;
            gnt_oh     <= '0;
            grant_id_o <= '0;
`ifdef EVENT_HEADER_EN
            hdr_pend   <= 1'b0;
            ev_cnt     <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (|req_i) begin
                        state      <= GRANT;
                        gnt_oh     <= rr_grant;
                        grant_id_o <= rr_idx;
                    end
                end
                GRANT: begin
                    state    <= BURST;
                    cnt      <= '0;
`ifdef EVENT_HEADER_EN
                    hdr_pend <= 1'b1;
`endif
                end
                BURST: begin
                    // full_i stalls everything: no write, count and state held.
                    if (!full_i) begin
`ifdef EVENT_HEADER_EN
                        if (hdr_pend)
                            hdr_pend <= 1'b0;
                        else
`endif
                        begin
                            cnt <= cnt + 1'b1;
                            if (cnt == CW'(WORDS_PER_EVENT - 1))
                                state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    ptr   <= (grant_id_o == IW'(N_REQ - 1)) ? '0
                                                            : grant_id_o + 1'b1;
`ifdef EVENT_HEADER_EN
                    ev_cnt <= ev_cnt + 32'd1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        wr_en_o   = 1'b0;
        din_o     = '0;
        ack_o     = '0;
        done_o    = '0;
        hdr_phase = 1'b0;
`ifdef EVENT_HEADER_EN
        hdr_phase = hdr_pend;
`endif
        busy_o    = (state != IDLE);
        if (state == BURST) begin
            wr_en_o = !full_i;
            din_o   = data_i[grant_id_o*64 +: 64];
`ifdef EVENT_HEADER_EN
            if (hdr_pend)
                din_o = {HEADER_TAG, 8'(grant_id_o), 16'h0000, ev_cnt};
`endif
            if (wr_en_o && !hdr_phase)
                ack_o = gnt_oh;
        end
        if (state == DONE)
            done_o = gnt_oh;
    end

endmodule

// File: tb/tb_event_write_arbiter.sv
// Self-checking bench for event_write_arbiter (N_REQ=4, 16 words per event).
// Table of single events plus round-robin, stall and mid-burst reset sequences.
`timescale 1ns/1ps
module tb_event_write_arbiter;
    import event_write_arbiter_pkg::*;

    localparam int N = 4;
    localparam int W = 16;
`ifdef EVENT_HEADER_EN
    localparam int HW = 1;
`else
    localparam int HW = 0;
`endif

    logic            clk = 1'b0;
    logic            aresetn = 1'b0;
    logic [N-1:0]    req_i = '0;
    logic [N*64-1:0] data_i;
    logic            full_i = 1'b0;
    logic            wr_en_o;
    logic [63:0]     din_o;
    logic [N-1:0]    ack_o;
    logic [N-1:0]    done_o;
    logic [1:0]      grant_id_o;
    logic            busy_o;

    always #5 clk = ~clk;

    event_write_arbiter #(.N_REQ(N), .WORDS_PER_EVENT(W)) dut (
        .clk        (clk),
        .aresetn    (aresetn),
        .req_i      (req_i),
        .data_i     (data_i),
        .full_i     (full_i),
        .wr_en_o    (wr_en_o),
        .din_o      (din_o),
        .ack_o      (ack_o),
        .done_o     (done_o),
        .grant_id_o (grant_id_o),
        .busy_o     (busy_o)
    );

    // Requester model: each presents its word index, advancing on ack.
    logic [31:0] wi [N] = '{default: '0};
    always @(posedge clk)
        for (int i = 0; i < N; i++)
            if (ack_o[i]) wi[i] <= wi[i] + 32'd1;

    for (genvar g = 0; g < N; g++) begin : g_data
        assign data_i[g*64 +: 64] = {8'hD0, 8'(g), 16'h0000, wi[g]};
    end

    typedef struct {
        logic [63:0]  din;
        logic [N-1:0] ack;
    } sb_t;

    typedef struct {
        logic [N-1:0] req;
        int           gid;
        int           stall_at;
        int           stall_len;
    } row_t;

    sb_t         sbq[$];
    row_t        rows[7];
    logic [31:0] exp_wi [N] = '{default: '0};
`ifdef EVENT_HEADER_EN
    logic [31:0] ev_exp = '0;
`endif
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_event(input int id);
        sb_t e;
`ifdef EVENT_HEADER_EN
        e.din = {HEADER_TAG, 8'(id), 16'h0000, ev_exp};
        e.ack = '0;
        sbq.push_back(e);
`endif
        for (int k = 0; k < W; k++) begin
            e.din     = {8'hD0, 8'(id), 16'h0000, exp_wi[id]};
            e.ack     = '0;
            e.ack[id] = 1'b1;
            exp_wi[id] = exp_wi[id] + 32'd1;
            sbq.push_back(e);
        end
    endtask

    task automatic sb_pop();
        sb_t e;
        if (sbq.size() == 0) begin
            check("sb_underflow", 64'd1, 64'd0);
        end else begin
            e = sbq.pop_front();
            check("din", din_o, e.din);
            check("ack", 64'(ack_o), 64'(e.ack));
        end
    endtask

    // Follow one event from GRANT to done_o, optionally stalling mid-burst.
    task automatic collect(input int gid, input int stall_at, input int stall_len,
                           input bit chk_lat, input bit drop_req);
        int writes, acks, first, last, cyc, stall_left;
        bit got_done, stalled;
        logic [N-1:0] oh;
        writes = 0; acks = 0; first = -1; last = -1; cyc = 0;
        stall_left = 0; got_done = 0; stalled = 0;
        push_event(gid);
        while (!got_done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (wr_en_o) begin
                writes++;
                if (first < 0) first = cyc;
                last = cyc;
                sb_pop();
            end
            if (|ack_o) acks++;
            if (full_i) begin
                check("stall_wr", 64'(wr_en_o), 64'd0);
                check("stall_ack", 64'(ack_o), 64'd0);
                stall_left--;
                if (stall_left == 0) full_i = 1'b0;
            end else if (stall_len > 0 && !stalled && wr_en_o &&
                         writes == stall_at) begin
                full_i     = 1'b1;
                stall_left = stall_len;
                stalled    = 1'b1;
            end
            if (|done_o) got_done = 1'b1;
        end
        check("done_seen", 64'(got_done), 64'd1);
        oh = '0;
        oh[gid] = 1'b1;
        check("done_oh", 64'(done_o), 64'(oh));
        check("grant_id", 64'(grant_id_o), 64'(gid));
        check("writes", 64'(writes), 64'(W + HW));
        check("acks", 64'(acks), 64'(W));
        check("burst_len", 64'(last - first + 1), 64'(W + HW + stall_len));
        if (chk_lat) check("latency", 64'(first), 64'd2);
`ifdef EVENT_HEADER_EN
        ev_exp = ev_exp + 32'd1;
`endif
        if (drop_req) req_i = '0;
    endtask

    initial begin
        int writes;
        int cyc;
        rows[0] = '{4'b0100, 2, 0, 0};
        rows[1] = '{4'b0001, 0, 0, 0};
        rows[2] = '{4'b0101, 2, 0, 0};
        rows[3] = '{4'b1000, 3, 8, 5};
        rows[4] = '{4'b0011, 0, 0, 0};
        rows[5] = '{4'b0011, 1, 0, 0};
        rows[6] = '{4'b1001, 3, 0, 0};

        repeat (2) @(negedge clk);
        check("rst_wr", 64'(wr_en_o), 64'd0);
        check("rst_din", din_o, 64'd0);
        check("rst_ack", 64'(ack_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_gid", 64'(grant_id_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        aresetn = 1'b1;
        @(negedge clk);

        for (int r = 0; r < 7; r++) begin
            req_i = rows[r].req;
            collect(rows[r].gid, rows[r].stall_at, rows[r].stall_len, 1'b1, 1'b1);
            @(negedge clk);
            check("idle_busy", 64'(busy_o), 64'd0);
        end

        req_i = 4'b1111;
        for (int k = 0; k < 5; k++)
            collect(k % 4, 0, 0, 1'b0, k == 4);
        @(negedge clk);

        // Abort an event from requester 2 after its 7th write.
        req_i = 4'b0100;
        push_event(2);
        writes = 0;
        cyc = 0;
        while (writes < 7 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (wr_en_o) begin
                writes++;
                sb_pop();
            end
        end
        check("pre_rst_writes", 64'(writes), 64'd7);
        aresetn = 1'b0;
        #1;
        check("mid_rst_wr", 64'(wr_en_o), 64'd0);
        check("mid_rst_din", din_o, 64'd0);
        check("mid_rst_ack", 64'(ack_o), 64'd0);
        check("mid_rst_gid", 64'(grant_id_o), 64'd0);
        check("mid_rst_busy", 64'(busy_o), 64'd0);
        sbq.delete();
        for (int i = 0; i < N; i++) exp_wi[i] = wi[i];
`ifdef EVENT_HEADER_EN
        ev_exp = '0;
`endif
        req_i = '0;
        @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
        req_i = 4'b1001;
        collect(0, 0, 0, 1'b1, 1'b1);
        @(negedge clk);
        check("sb_empty", 64'(sbq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/event_write_arbiter.md
EVENT_WRITE_ARBITER -- requirements
Module: event_write_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of event requesters (2..16).
REQ-002 Parameter WORDS_PER_EVENT, default 16: 64-bit data words per event burst.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 aresetn  input  1  asynchronous, active-low reset.
REQ-005 req_i  input  N_REQ  per-requester event-ready level, held high until its done_o pulse.
REQ-006 data_i  input  N_REQ x 64  per-requester current word; requester advances to next word on its ack_o.
REQ-007 full_i  input  1  shared FIFO full flag.
REQ-008 wr_en_o  output  1  shared FIFO write strobe.
REQ-009 din_o  output  64  shared FIFO write data.
REQ-010 ack_o  output  N_REQ  one-cycle pulse per data word accepted from the granted requester.
REQ-011 done_o  output  N_REQ  one-cycle pulse when the granted requester's event is fully written.
REQ-012 grant_id_o  output  $clog2(N_REQ)  index of the current or last granted requester.
REQ-013 busy_o  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states SHALL be IDLE, GRANT, BURST and DONE, held in a registered state variable.
REQ-015 IDLE: any req_i bit high -> GRANT next cycle; grant index registered at that edge.
REQ-016 Arbitration SHALL be round-robin: the first set req_i bit at or above the priority pointer wins, wrapping modulo N_REQ.
REQ-017 GRANT SHALL last exactly one cycle, then go to BURST.
REQ-018 BURST: wr_en_o = !full_i; din_o = data_i[grant]; ack_o[grant] = wr_en_o; all other ack_o bits 0.
REQ-019 full_i high in BURST SHALL stall: no write, no ack, word counter held, state held; no timeout.
REQ-020 Word counter width SHALL be $clog2(WORDS_PER_EVENT+1); it clears on entry to BURST and increments per write.
REQ-021 The write that makes the count equal WORDS_PER_EVENT SHALL move the FSM to DONE on the next edge.
REQ-022 DONE SHALL last one cycle: done_o[grant]=1, pointer <= grant+1 mod N_REQ, next state IDLE.
REQ-023 req_i SHALL NOT be sampled outside IDLE; a requester dropping req_i mid-burst does not abort the burst.
REQ-024 Back-to-back events SHALL cost 3 overhead cycles (DONE, IDLE, GRANT); with full_i low, first write occurs 2 cycles after req_i rises in IDLE.
REQ-025 Outside BURST, wr_en_o, din_o and ack_o SHALL be 0; done_o SHALL be 0 outside DONE.

Reset
REQ-026 aresetn low SHALL immediately force state IDLE, counter 0, pointer 0, grant_id_o 0 and all outputs 0, including mid-burst; the partially written event is not resumed.

Configuration
REQ-027 With EVENT_HEADER_EN defined, BURST SHALL write one header word before the data words: {8'hEA, 8-bit grant index, 16'h0000, 32-bit event count}.
REQ-028 Under EVENT_HEADER_EN, the header write SHALL produce no ack_o, stalls on full_i like data, and the burst totals WORDS_PER_EVENT+1 writes.
REQ-029 Under EVENT_HEADER_EN, the 32-bit event count SHALL reset to 0, increment in every DONE and wrap from 2^32-1 to 0.
REQ-030 Without EVENT_HEADER_EN, there SHALL be no header logic and exactly WORDS_PER_EVENT writes per burst.

Structure
REQ-031 The shared package SHALL hold the state enum, the header tag constant 8'hEA and the default WORDS_PER_EVENT.
REQ-032 The round-robin selector SHALL be a sub-module rr_arbiter (request vector and pointer in, one-hot grant and index out, combinational).

Verification
REQ-033 Single request: req_i=4'b0100, full_i=0 -> grant_id_o=2, 16 consecutive wr_en_o/ack_o[2] pulses with din_o=data_i[2], then done_o[2] pulse.
REQ-034 Round-robin: req_i=4'b1111 held throughout -> grant order 0,1,2,3,0; each burst 16 writes.
REQ-035 Stall: full_i high for 5 cycles after write 8 -> exactly 16 writes, BURST extended by 5 cycles, no ack during stall.
REQ-036 Reset mid-burst: aresetn low after write 7 -> all outputs 0 immediately; next request is granted from pointer 0.
REQ-037 EVENT_HEADER_EN: two events from requester 1 -> first word 0xEA01_0000_0000_0000 then 0xEA01_0000_0000_0001; 17 writes each and 16 acks each.
REQ-038 Pointer wrap: N_REQ=4, pointer=3, req_i=4'b0001 -> grant 0; after done_o, pointer=1.
